// File: rtl/dmac_cmd_arbiter.sv
// dmac_cmd_arbiter: round-robin front-end that takes commands from NUM_CH requesters,
// splits each into chunks of at most CHUNK_BYTES and issues them on the single DMAC cmd port.
module dmac_cmd_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_ADDR_WD = 16,
  parameter int CHUNK_BYTES = 1024
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESETN,
  input  logic [NUM_CH-1:0]             ch_cmd_valid,
  output logic [NUM_CH-1:0]             ch_cmd_ready,
  input  logic [NUM_CH*AXI_ADDR_WD-1:0] ch_cmd_addr,
  input  logic [NUM_CH*2-1:0]           ch_cmd_burst,
  input  logic [NUM_CH*3-1:0]           ch_cmd_size,
  input  logic [NUM_CH*AXI_ADDR_WD-1:0] ch_cmd_len,
  output logic [NUM_CH-1:0]             ch_done,
  output logic [NUM_CH-1:0]             ch_aborted,
  output logic                          cmd_valid,
  output logic [AXI_ADDR_WD-1:0]        cmd_addr,
  output logic [AXI_ID_WD-1:0]          cmd_id,
  output logic [1:0]                    cmd_burst,
  output logic [2:0]                    cmd_size,
  output logic [AXI_ADDR_WD-1:0]        cmd_len,
  input  logic                          cmd_ready,
  input  logic                          cmd_abort
);
  localparam logic [AXI_ADDR_WD-1:0] CHUNK = AXI_ADDR_WD'(CHUNK_BYTES);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE, ABORT} state_t;
  state_t state, next_state;
  logic [AXI_ID_WD-1:0] rr_ptr, grant, id_next;
  logic [NUM_CH-1:0] rot;
  logic [AXI_ADDR_WD-1:0] rem, rem_left, g_addr, g_len;
  logic [1:0] g_burst;
  logic [2:0] g_size;
  logic any_req, accept, hs, more;
  assign any_req  = |ch_cmd_valid;
  assign accept   = state == IDLE && any_req;
  assign hs       = state == ISSUE && cmd_valid && cmd_ready;
  // WRAP and reserved bursts (burst[1] set) are always issued whole
  assign more     = !cmd_burst[1] && rem > CHUNK;
  assign rem_left = rem - CHUNK;
  assign rot      = NUM_CH'({ch_cmd_valid, ch_cmd_valid} >> rr_ptr);
  always_comb begin
    grant = rr_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) grant = AXI_ID_WD'(int'(rr_ptr) + k >= NUM_CH ? int'(rr_ptr) + k - NUM_CH : int'(rr_ptr) + k);
  end
  always_comb begin
    g_addr  = '0;
    g_len   = '0;
    g_burst = '0;
    g_size  = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (int'(grant) == c) begin
        g_addr  = ch_cmd_addr[c*AXI_ADDR_WD +: AXI_ADDR_WD];
        g_len   = ch_cmd_len[c*AXI_ADDR_WD +: AXI_ADDR_WD];
        g_burst = ch_cmd_burst[c*2 +: 2];
        g_size  = ch_cmd_size[c*3 +: 3];
      end
  end
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
    if (!AXI_ARESETN) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = g_len == '0 ? DONE : ISSUE;
      ISSUE:   if (hs) next_state = more ? (cmd_abort ? ABORT : ISSUE) : DONE;
               else if (cmd_abort) next_state = ABORT;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    id_next      = state == IDLE ? grant : cmd_id;
    ch_cmd_ready = accept && AXI_ARESETN ? NUM_CH'(1) << grant : '0;
  end
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
    if (!AXI_ARESETN) begin
      rr_ptr     <= '0;
      rem        <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_id     <= '0;
      cmd_burst  <= '0;
      cmd_size   <= '0;
      cmd_len    <= '0;
      ch_done    <= '0;
      ch_aborted <= '0;
    end else begin
      cmd_valid  <= next_state == ISSUE;
      ch_done    <= next_state == DONE ? NUM_CH'(1) << id_next : '0;
      ch_aborted <= next_state == ABORT ? NUM_CH'(1) << id_next : '0;
      if (accept) begin
        rr_ptr    <= int'(grant) == NUM_CH - 1 ? '0 : grant + 1'b1;
        rem       <= g_len;
        cmd_addr  <= g_addr;
        cmd_id    <= grant;
        cmd_burst <= g_burst;
        cmd_size  <= g_size;
        cmd_len   <= !g_burst[1] && g_len > CHUNK ? CHUNK : g_len;
      end else if (hs && more) begin
        rem      <= rem_left;
        cmd_addr <= cmd_addr + (cmd_burst == 2'b01 ? CHUNK : '0);
        cmd_len  <= rem_left > CHUNK ? CHUNK : rem_left;
      end
    end
endmodule
